id_ex_stage: RTL and testbench
==============================

# id_ex_stage

ID/EX pipeline stage of the five-stage MIPS pipeline, sitting directly upstream of the execute-stage ALU. It performs four jobs:
- Registers decoded operands and control each clock.
- Decodes ALU control (Operation/Binvert/Cin) from ALUOp and funct.
- Applies EX/MEM and MEM/WB operand forwarding to produce the ALU's `in1`/`in2`.
- Detects load-use hazards and inserts bubbles.

Supports external stall and flush (branch/exception squash).

## Interface
Parameters: none (widths fixed, 32-bit data, 5-bit register specifiers).

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  synchronous reset, active-low
- stall  in  1  hold register contents (memory stall)
- flush  in  1  squash: load a bubble
- id_valid  in  1  ID stage holds a real instruction
- id_rs_data, id_rt_data  in  32  register-file read data
- id_imm  in  32  sign/zero-extended immediate
- id_rs, id_rt, id_rd  in  5  register specifiers
- id_aluop  in  2  00 add, 01 sub, 10 R-type (use funct), 11 or (ori)
- id_funct  in  6  R-type funct field
- id_alusrc, id_regdst, id_regwrite, id_memread, id_memwrite, id_memtoreg  in  1  decoded control
- exmem_regwrite  in  1, exmem_rd  in  5, exmem_result  in  32  EX/MEM forwarding source
- memwb_regwrite  in  1, memwb_rd  in  5, memwb_result  in  32  MEM/WB forwarding source
- in1, in2  out  32  ALU operands
- Operation  out  2  ALU select: 00 and, 01 or, 10 sum
- Binvert, Cin  out  1  ALU invert/carry-in
- ex_slt  out  1  result is set-less-than (take sum sign bit)
- ex_illegal  out  1  unsupported funct
- ex_valid, ex_regwrite, ex_memread, ex_memwrite, ex_memtoreg  out  1  registered control
- ex_dest  out  5  destination (rd if regdst else rt)
- ex_store_data  out  32  forwarded rt value for stores
- load_use_stall  out  1  combinational: upstream must hold PC and IF/ID

## Operation
- Register update priority, each rising edge: `!rst_n` > `flush` > `stall` > `load_use_stall` > normal load.
  - Reset: all stored fields 0.
  - Flush: bubble (all control 0, ex_valid 0, dest 0).
  - Stall: hold.
  - Load-use: bubble.
  - Normal: capture ID inputs.
- Bubble/reset: ex_valid=0, all write/mem controls 0.
- ALU decode (computed in ID, registered):
  - add (aluop 00, funct 100000): Op=10, Binvert=0, Cin=0
  - sub (aluop 01, funct 100010): Op=10, Binvert=1, Cin=1
  - and 100100: Op=00
  - or 100101 or aluop 11: Op=01
  - slt 101010: Op=10, Binvert=1, Cin=1, ex_slt=1
  - any other funct under aluop 10: add encoding, ex_illegal=1, ex_regwrite forced 0
- Forwarding (combinational from registered rs/rt):
  - EX/MEM match (regwrite, rd!=0, rd==ex_rs/ex_rt) wins over MEM/WB match.
  - No match: registered read data.
  - Register 0 is never forwarded.
  - in1 = fwd(rs); ex_store_data = fwd(rt); in2 = alusrc ? imm : fwd(rt).
- Load-use: load_use_stall = ex_valid & ex_memread & ex_dest!=0 & id_valid & (ex_dest==id_rs | ex_dest==id_rt).
  - Asserted only when stall=0 and flush=0; otherwise 0.

## Timing
- Latency: 1 cycle from ID inputs to registered outputs; in1/in2 also follow forwarding inputs in the same cycle.
- After reset release, all outputs are 0: in1=in2=0, Operation=00, Binvert=Cin=0, load_use_stall=0.
- Load-use: exactly one bubble per dependent load; on the next cycle ex_memread=0, so the stall deasserts and the held instruction loads, with MEM/WB forwarding supplying the loaded value.
- Flush and stall in the same cycle: flush wins.
- Reset mid-stall: register cleared on that edge.

## Configuration
- `ID_EX_FWD_EN` defined: forwarding muxes present as above.
- `ID_EX_FWD_EN` undefined:
  - Forwarding inputs are ignored.
  - in1 = registered rs data; in2 = alusrc ? imm : registered rt data; ex_store_data = registered rt data.
  - load_use_stall logic is unchanged; software schedules other hazards.

## Test plan
- Reset: hold rst_n=0 two cycles with random inputs -> all outputs 0 the cycle after release.
- `sub` (funct 100010, rs_data=7, rt_data=3) -> next cycle in1=7, in2=3, Operation=10, Binvert=1, Cin=1.
- EX/MEM and MEM/WB both write rd=5 (0xAAAA, 0x5555), ex_rs=5 -> in1=0xAAAA. Same with rd=0 -> in1=registered rs data.
- lw to $t1 in EX, id_rs=9, id_valid=1 -> load_use_stall=1, next cycle ex_valid=0, following cycle instruction captured with memwb forward.
- stall=1 with new ID inputs -> outputs unchanged. flush=1 and stall=1 together -> ex_valid=0, ex_regwrite=0.
- funct 000000 under aluop 10 -> ex_illegal=1, ex_regwrite=0, Operation=10.

Source files
------------

// File: rtl/id_ex_stage_if.sv
// Signal bundle between the ID stage, forwarding sources and the ID/EX register.
// master drives decoded ID fields and forwarding sources; slave is id_ex_stage.
interface id_ex_stage_if;
  logic        stall;
  logic        flush;
  logic        id_valid;
  logic [31:0] id_rs_data;
  logic [31:0] id_rt_data;
  logic [31:0] id_imm;
  logic [4:0]  id_rs;
  logic [4:0]  id_rt;
  logic [4:0]  id_rd;
  logic [1:0]  id_aluop;
  logic [5:0]  id_funct;
  logic        id_alusrc;
  logic        id_regdst;
  logic        id_regwrite;
  logic        id_memread;
  logic        id_memwrite;
  logic        id_memtoreg;
  logic        exmem_regwrite;
  logic [4:0]  exmem_rd;
  logic [31:0] exmem_result;
  logic        memwb_regwrite;
  logic [4:0]  memwb_rd;
  logic [31:0] memwb_result;
  logic [31:0] in1;
  logic [31:0] in2;
  logic [1:0]  Operation;
  logic        Binvert;
  logic        Cin;
  logic        ex_slt;
  logic        ex_illegal;
  logic        ex_valid;
  logic        ex_regwrite;
  logic        ex_memread;
  logic        ex_memwrite;
  logic        ex_memtoreg;
  logic [4:0]  ex_dest;
  logic [31:0] ex_store_data;
  logic        load_use_stall;

  modport master (
    output stall, flush, id_valid, id_rs_data, id_rt_data, id_imm,
           id_rs, id_rt, id_rd, id_aluop, id_funct,
           id_alusrc, id_regdst, id_regwrite, id_memread, id_memwrite, id_memtoreg,
           exmem_regwrite, exmem_rd, exmem_result,
           memwb_regwrite, memwb_rd, memwb_result,
    input  in1, in2, Operation, Binvert, Cin, ex_slt, ex_illegal,
           ex_valid, ex_regwrite, ex_memread, ex_memwrite, ex_memtoreg,
           ex_dest, ex_store_data, load_use_stall
  );

  modport slave (
    input  stall, flush, id_valid, id_rs_data, id_rt_data, id_imm,
           id_rs, id_rt, id_rd, id_aluop, id_funct,
           id_alusrc, id_regdst, id_regwrite, id_memread, id_memwrite, id_memtoreg,
           exmem_regwrite, exmem_rd, exmem_result,
           memwb_regwrite, memwb_rd, memwb_result,
    output in1, in2, Operation, Binvert, Cin, ex_slt, ex_illegal,
           ex_valid, ex_regwrite, ex_memread, ex_memwrite, ex_memtoreg,
           ex_dest, ex_store_data, load_use_stall
  );
endinterface

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with ALU-control decode, operand forwarding and load-use bubbling.
// Define ID_EX_FWD_EN to build the EX/MEM and MEM/WB forwarding muxes; otherwise operands come straight from the register.
module id_ex_stage (
  input logic         clk,
  input logic         rst_n,
  id_ex_stage_if.slave bus
);

  localparam logic [1:0] ALUOP_ADD = 2'b00;
  localparam logic [1:0] ALUOP_SUB = 2'b01;
  localparam logic [1:0] ALUOP_OR  = 2'b11;

  localparam logic [5:0] FN_ADD = 6'b100000;
  localparam logic [5:0] FN_SUB = 6'b100010;
  localparam logic [5:0] FN_AND = 6'b100100;
  localparam logic [5:0] FN_OR  = 6'b100101;
  localparam logic [5:0] FN_SLT = 6'b101010;

  localparam logic [1:0] OP_AND = 2'b00;
  localparam logic [1:0] OP_OR  = 2'b01;
  localparam logic [1:0] OP_SUM = 2'b10;

  typedef struct packed {
    logic        valid;
    logic        regwrite;
    logic        memread;
    logic        memwrite;
    logic        memtoreg;
    logic        alusrc;
    logic [1:0]  op;
    logic        binvert;
    logic        cin;
    logic        slt;
    logic        illegal;
    logic [4:0]  rs;
    logic [4:0]  rt;
    logic [4:0]  dest;
    logic [31:0] rs_data;
    logic [31:0] rt_data;
    logic [31:0] imm;
  } ex_reg_t;

  ex_reg_t     ex_q;
  ex_reg_t     ex_d;
  logic [1:0]  dec_op;
  logic        dec_binvert;
  logic        dec_cin;
  logic        dec_slt;
  logic        dec_illegal;
  logic [31:0] rs_fwd;
  logic [31:0] rt_fwd;

  always_comb begin
    dec_op      = OP_SUM;
    dec_binvert = 1'b0;
    dec_cin     = 1'b0;
    dec_slt     = 1'b0;
    dec_illegal = 1'b0;
    case (bus.id_aluop)
      ALUOP_ADD: dec_op = OP_SUM;
      ALUOP_SUB: begin
        dec_binvert = 1'b1;
        dec_cin     = 1'b1;
      end
      ALUOP_OR:  dec_op = OP_OR;
      default: begin
        case (bus.id_funct)
          FN_ADD: dec_op = OP_SUM;
          FN_SUB: begin
            dec_binvert = 1'b1;
            dec_cin     = 1'b1;
          end
          FN_AND: dec_op = OP_AND;
          FN_OR:  dec_op = OP_OR;
          FN_SLT: begin
            dec_binvert = 1'b1;
            dec_cin     = 1'b1;
            dec_slt     = 1'b1;
          end
          // unknown funct still runs as an add but never writes back
          default: dec_illegal = 1'b1;
        endcase
      end
    endcase
  end

  always_comb begin
    ex_d          = '0;
    ex_d.valid    = bus.id_valid;
    ex_d.regwrite = bus.id_regwrite & ~dec_illegal;
    ex_d.memread  = bus.id_memread;
    ex_d.memwrite = bus.id_memwrite;
    ex_d.memtoreg = bus.id_memtoreg;
    ex_d.alusrc   = bus.id_alusrc;
    ex_d.op       = dec_op;
    ex_d.binvert  = dec_binvert;
    ex_d.cin      = dec_cin;
    ex_d.slt      = dec_slt;
    ex_d.illegal  = dec_illegal;
    ex_d.rs       = bus.id_rs;
    ex_d.rt       = bus.id_rt;
    ex_d.dest     = bus.id_regdst ? bus.id_rd : bus.id_rt;
    ex_d.rs_data  = bus.id_rs_data;
    ex_d.rt_data  = bus.id_rt_data;
    ex_d.imm      = bus.id_imm;
  end

  // load_use_stall is already forced low under stall/flush, so flush beats stall here
  always_ff @(posedge clk) begin
    if (!rst_n || bus.flush || bus.load_use_stall) begin
      ex_q <= '0;
    end else if (!bus.stall) begin
      ex_q <= ex_d;
    end
  end

  assign bus.load_use_stall = ~bus.stall & ~bus.flush & ex_q.valid & ex_q.memread &
                              (ex_q.dest != 5'd0) & bus.id_valid &
                              ((ex_q.dest == bus.id_rs) | (ex_q.dest == bus.id_rt));

`ifdef ID_EX_FWD_EN
  always_comb begin
    rs_fwd = ex_q.rs_data;
    if (bus.exmem_regwrite && (bus.exmem_rd != 5'd0) && (bus.exmem_rd == ex_q.rs)) begin
      rs_fwd = bus.exmem_result;
    end else if (bus.memwb_regwrite && (bus.memwb_rd != 5'd0) && (bus.memwb_rd == ex_q.rs)) begin
      rs_fwd = bus.memwb_result;
    end
  end

  always_comb begin
    rt_fwd = ex_q.rt_data;
    if (bus.exmem_regwrite && (bus.exmem_rd != 5'd0) && (bus.exmem_rd == ex_q.rt)) begin
      rt_fwd = bus.exmem_result;
    end else if (bus.memwb_regwrite && (bus.memwb_rd != 5'd0) && (bus.memwb_rd == ex_q.rt)) begin
      rt_fwd = bus.memwb_result;
    end
  end
`else
  logic unused_fwd;
  assign unused_fwd = ^{bus.exmem_regwrite, bus.exmem_rd, bus.exmem_result,
                        bus.memwb_regwrite, bus.memwb_rd, bus.memwb_result};
  assign rs_fwd = ex_q.rs_data;
  assign rt_fwd = ex_q.rt_data;
`endif

  assign bus.in1           = rs_fwd;
  assign bus.in2           = ex_q.alusrc ? ex_q.imm : rt_fwd;
  assign bus.ex_store_data = rt_fwd;
  assign bus.Operation     = ex_q.op;
  assign bus.Binvert       = ex_q.binvert;
  assign bus.Cin           = ex_q.cin;
  assign bus.ex_slt        = ex_q.slt;
  assign bus.ex_illegal    = ex_q.illegal;
  assign bus.ex_valid      = ex_q.valid;
  assign bus.ex_regwrite   = ex_q.regwrite;
  assign bus.ex_memread    = ex_q.memread;
  assign bus.ex_memwrite   = ex_q.memwrite;
  assign bus.ex_memtoreg   = ex_q.memtoreg;
  assign bus.ex_dest       = ex_q.dest;

endmodule

// File: tb/tb_id_ex_stage.sv
// Self-checking bench for id_ex_stage: directed literal cases plus randomized traffic
// compared every cycle against an instruction-level model of the ID/EX register.
module tb_id_ex_stage;
  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  id_ex_stage_if bus();
  id_ex_stage dut (.clk(clk), .rst_n(rst_n), .bus(bus));

`ifdef ID_EX_FWD_EN
  localparam bit FWD = 1'b1;
`else
  localparam bit FWD = 1'b0;
`endif

  int total = 0;
  int bad   = 0;
  bit cmp_en = 1'b0;

  typedef struct {
    bit        valid, regwrite, memread, memwrite, memtoreg, alusrc;
    bit        binv, cin, slt, illegal;
    bit [1:0]  op;
    bit [4:0]  rs, rt, dest;
    bit [31:0] rs_data, rt_data, imm;
  } ex_t;
  ex_t m;

  bit [5:0] functs [5] = '{6'h20, 6'h22, 6'h24, 6'h25, 6'h2a};

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h at %0t", name, act, exp, $time);
    end
  endtask

  // instruction kind: 0 add, 1 sub, 2 and, 3 or, 4 slt, 5 illegal
  function automatic int kind_of(input bit [1:0] aluop, input bit [5:0] funct);
    if (aluop == 2'd0) return 0;
    if (aluop == 2'd1) return 1;
    if (aluop == 2'd3) return 3;
    if (funct == 6'h20) return 0;
    if (funct == 6'h22) return 1;
    if (funct == 6'h24) return 2;
    if (funct == 6'h25) return 3;
    if (funct == 6'h2a) return 4;
    return 5;
  endfunction

  function automatic bit [31:0] fwd(input bit [4:0] r, input bit [31:0] d);
    if (!FWD || r == 5'd0) return d;
    if (bus.exmem_regwrite && bus.exmem_rd == r) return bus.exmem_result;
    if (bus.memwb_regwrite && bus.memwb_rd == r) return bus.memwb_result;
    return d;
  endfunction

  function automatic bit m_lus();
    if (bus.stall || bus.flush) return 1'b0;
    if (!(m.valid && m.memread && bus.id_valid) || m.dest == 5'd0) return 1'b0;
    return (m.dest == bus.id_rs) || (m.dest == bus.id_rt);
  endfunction

  task automatic model_update();
    int k;
    if (!rst_n) m = '{default: '0};
    else if (bus.flush) m = '{default: '0};
    else if (bus.stall) begin end
    else if (m_lus()) m = '{default: '0};
    else begin
      k = kind_of(bus.id_aluop, bus.id_funct);
      m.valid    = bus.id_valid;
      m.regwrite = bus.id_regwrite && (k != 5);
      m.memread  = bus.id_memread;
      m.memwrite = bus.id_memwrite;
      m.memtoreg = bus.id_memtoreg;
      m.alusrc   = bus.id_alusrc;
      m.op       = (k == 2) ? 2'b00 : (k == 3) ? 2'b01 : 2'b10;
      m.binv     = (k == 1) || (k == 4);
      m.cin      = (k == 1) || (k == 4);
      m.slt      = (k == 4);
      m.illegal  = (k == 5);
      m.rs       = bus.id_rs;
      m.rt       = bus.id_rt;
      m.dest     = bus.id_regdst ? bus.id_rd : bus.id_rt;
      m.rs_data  = bus.id_rs_data;
      m.rt_data  = bus.id_rt_data;
      m.imm      = bus.id_imm;
    end
  endtask

  always @(negedge clk) begin
    if (cmp_en) begin
      chk("in1", bus.in1, fwd(m.rs, m.rs_data));
      chk("in2", bus.in2, m.alusrc ? m.imm : fwd(m.rt, m.rt_data));
      chk("store_data", bus.ex_store_data, fwd(m.rt, m.rt_data));
      chk("Operation", 32'(bus.Operation), 32'(m.op));
      chk("Binvert", 32'(bus.Binvert), 32'(m.binv));
      chk("Cin", 32'(bus.Cin), 32'(m.cin));
      chk("ex_slt", 32'(bus.ex_slt), 32'(m.slt));
      chk("ex_illegal", 32'(bus.ex_illegal), 32'(m.illegal));
      chk("ex_valid", 32'(bus.ex_valid), 32'(m.valid));
      chk("ex_regwrite", 32'(bus.ex_regwrite), 32'(m.regwrite));
      chk("ex_memread", 32'(bus.ex_memread), 32'(m.memread));
      chk("ex_memwrite", 32'(bus.ex_memwrite), 32'(m.memwrite));
      chk("ex_memtoreg", 32'(bus.ex_memtoreg), 32'(m.memtoreg));
      chk("ex_dest", 32'(bus.ex_dest), 32'(m.dest));
      chk("load_use_stall", 32'(bus.load_use_stall), 32'(m_lus()));
    end
  end

  task automatic tick();
    @(posedge clk);
    model_update();
    #2;
  endtask

  task automatic settle();
    @(negedge clk);
    #1;
  endtask

  task automatic idle();
    bus.stall = 0; bus.flush = 0; bus.id_valid = 0;
    bus.id_rs_data = '0; bus.id_rt_data = '0; bus.id_imm = '0;
    bus.id_rs = '0; bus.id_rt = '0; bus.id_rd = '0;
    bus.id_aluop = '0; bus.id_funct = '0;
    bus.id_alusrc = 0; bus.id_regdst = 0; bus.id_regwrite = 0;
    bus.id_memread = 0; bus.id_memwrite = 0; bus.id_memtoreg = 0;
    bus.exmem_regwrite = 0; bus.exmem_rd = '0; bus.exmem_result = '0;
    bus.memwb_regwrite = 0; bus.memwb_rd = '0; bus.memwb_result = '0;
  endtask

  task automatic rand_inputs();
    bit v;
    v = ($urandom_range(0, 3) != 0);
    bus.stall      = ($urandom_range(0, 7) == 0);
    bus.flush      = ($urandom_range(0, 15) == 0);
    bus.id_valid   = v;
    bus.id_rs_data = $urandom;
    bus.id_rt_data = $urandom;
    bus.id_imm     = $urandom;
    bus.id_rs      = 5'($urandom_range(0, 7));
    bus.id_rt      = 5'($urandom_range(0, 7));
    bus.id_rd      = 5'($urandom_range(0, 7));
    bus.id_aluop   = 2'($urandom_range(0, 3));
    bus.id_funct   = ($urandom_range(0, 3) == 0) ? 6'($urandom) : functs[$urandom_range(0, 4)];
    bus.id_alusrc  = v && ($urandom_range(0, 1) == 1);
    bus.id_regdst  = v && ($urandom_range(0, 1) == 1);
    bus.id_regwrite = v && ($urandom_range(0, 1) == 1);
    bus.id_memread  = v && ($urandom_range(0, 2) == 0);
    bus.id_memwrite = v && ($urandom_range(0, 3) == 0);
    bus.id_memtoreg = v && ($urandom_range(0, 1) == 1);
    bus.exmem_regwrite = ($urandom_range(0, 1) == 1);
    bus.exmem_rd       = 5'($urandom_range(0, 7));
    bus.exmem_result   = $urandom;
    bus.memwb_regwrite = ($urandom_range(0, 1) == 1);
    bus.memwb_rd       = 5'($urandom_range(0, 7));
    bus.memwb_result   = $urandom;
  endtask

  initial begin
    // reset held two edges under random inputs
    rand_inputs(); rst_n = 1'b0;
    tick();
    cmp_en = 1'b1;
    rand_inputs(); rst_n = 1'b0;
    tick();
    rand_inputs(); rst_n = 1'b1;
    settle();
    chk("rst in1", bus.in1, 32'h0);
    chk("rst in2", bus.in2, 32'h0);
    chk("rst Operation", 32'(bus.Operation), 32'h0);
    chk("rst Binvert", 32'(bus.Binvert), 32'h0);
    chk("rst Cin", 32'(bus.Cin), 32'h0);
    chk("rst load_use", 32'(bus.load_use_stall), 32'h0);
    chk("rst ex_valid", 32'(bus.ex_valid), 32'h0);
    idle();
    tick();

    // sub 7 - 3
    idle();
    bus.id_valid = 1; bus.id_aluop = 2'b01; bus.id_funct = 6'b100010;
    bus.id_rs = 5'd1; bus.id_rt = 5'd2; bus.id_rd = 5'd3;
    bus.id_rs_data = 32'd7; bus.id_rt_data = 32'd3; bus.id_regdst = 1; bus.id_regwrite = 1;
    tick();
    idle();
    settle();
    chk("sub in1", bus.in1, 32'd7);
    chk("sub in2", bus.in2, 32'd3);
    chk("sub Operation", 32'(bus.Operation), 32'h2);
    chk("sub Binvert", 32'(bus.Binvert), 32'h1);
    chk("sub Cin", 32'(bus.Cin), 32'h1);
    chk("sub dest", 32'(bus.ex_dest), 32'd3);

    // forwarding priority on rs=5
    idle();
    bus.id_valid = 1; bus.id_aluop = 2'b10; bus.id_funct = 6'h20;
    bus.id_rs = 5'd5; bus.id_rs_data = 32'h1111; bus.id_rt = 5'd6; bus.id_rt_data = 32'h2222;
    bus.id_regdst = 1; bus.id_rd = 5'd7; bus.id_regwrite = 1;
    tick();
    idle();
    bus.exmem_regwrite = 1; bus.exmem_rd = 5'd5; bus.exmem_result = 32'hAAAA;
    bus.memwb_regwrite = 1; bus.memwb_rd = 5'd5; bus.memwb_result = 32'h5555;
    settle();
    chk("fwd exmem wins", bus.in1, FWD ? 32'hAAAA : 32'h1111);
    chk("fwd rt none", bus.in2, 32'h2222);
    bus.exmem_regwrite = 0;
    #1;
    chk("fwd memwb", bus.in1, FWD ? 32'h5555 : 32'h1111);

    // register 0 is never forwarded
    idle();
    bus.id_valid = 1; bus.id_rs = 5'd0; bus.id_rs_data = 32'h1234;
    tick();
    idle();
    bus.exmem_regwrite = 1; bus.exmem_rd = 5'd0; bus.exmem_result = 32'hAAAA;
    bus.memwb_regwrite = 1; bus.memwb_rd = 5'd0; bus.memwb_result = 32'h5555;
    settle();
    chk("fwd r0", bus.in1, 32'h1234);

    // lw $9 followed by dependent add
    idle();
    bus.id_valid = 1; bus.id_aluop = 2'b00; bus.id_alusrc = 1; bus.id_imm = 32'h10;
    bus.id_rt = 5'd9; bus.id_regwrite = 1; bus.id_memread = 1; bus.id_memtoreg = 1;
    tick();
    idle();
    bus.id_valid = 1; bus.id_aluop = 2'b10; bus.id_funct = 6'h20;
    bus.id_rs = 5'd9; bus.id_rs_data = 32'h0BAD; bus.id_rt = 5'd2; bus.id_rt_data = 32'h22;
    bus.id_regdst = 1; bus.id_rd = 5'd10; bus.id_regwrite = 1;
    #1;
    chk("lu stall", 32'(bus.load_use_stall), 32'h1);
    tick();
    settle();
    chk("lu bubble valid", 32'(bus.ex_valid), 32'h0);
    chk("lu released", 32'(bus.load_use_stall), 32'h0);
    bus.memwb_regwrite = 1; bus.memwb_rd = 5'd9; bus.memwb_result = 32'hBEEF;
    tick();
    bus.id_valid = 0;
    settle();
    chk("lu captured", 32'(bus.ex_valid), 32'h1);
    chk("lu fwd in1", bus.in1, FWD ? 32'hBEEF : 32'h0BAD);
    chk("lu dest", 32'(bus.ex_dest), 32'd10);

    // stall holds, then flush beats stall
    idle();
    bus.id_valid = 1; bus.id_aluop = 2'b11; bus.id_rs = 5'd3; bus.id_rs_data = 32'h33;
    bus.id_rt = 5'd4; bus.id_rt_data = 32'h44; bus.id_regdst = 1; bus.id_rd = 5'd12; bus.id_regwrite = 1;
    tick();
    bus.id_rs_data = 32'h99; bus.id_rt_data = 32'h88; bus.id_rd = 5'd13; bus.id_aluop = 2'b01;
    bus.stall = 1;
    tick();
    idle();
    settle();
    chk("stall in1", bus.in1, 32'h33);
    chk("stall dest", 32'(bus.ex_dest), 32'd12);
    chk("stall Operation", 32'(bus.Operation), 32'h1);
    bus.id_valid = 1; bus.id_regwrite = 1; bus.stall = 1; bus.flush = 1;
    tick();
    idle();
    settle();
    chk("flush valid", 32'(bus.ex_valid), 32'h0);
    chk("flush regwrite", 32'(bus.ex_regwrite), 32'h0);

    // reset while stalled
    bus.id_valid = 1; bus.id_regdst = 1; bus.id_rd = 5'd8; bus.id_regwrite = 1;
    tick();
    bus.stall = 1; rst_n = 0;
    tick();
    rst_n = 1; idle();
    settle();
    chk("rst stall valid", 32'(bus.ex_valid), 32'h0);
    chk("rst stall dest", 32'(bus.ex_dest), 32'h0);

    // illegal funct and slt
    idle();
    bus.id_valid = 1; bus.id_aluop = 2'b10; bus.id_funct = 6'h00; bus.id_regwrite = 1;
    tick();
    bus.id_funct = 6'h2a;
    settle();
    chk("ill flag", 32'(bus.ex_illegal), 32'h1);
    chk("ill regwrite", 32'(bus.ex_regwrite), 32'h0);
    chk("ill Operation", 32'(bus.Operation), 32'h2);
    tick();
    idle();
    settle();
    chk("slt flag", 32'(bus.ex_slt), 32'h1);
    chk("slt Binvert", 32'(bus.Binvert), 32'h1);
    chk("slt regwrite", 32'(bus.ex_regwrite), 32'h1);

    for (int i = 0; i < 4000; i++) begin
      rand_inputs();
      rst_n = ($urandom_range(0, 49) != 0);
      tick();
    end
    idle(); rst_n = 1;
    tick();
    settle();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
